// File: rtl/sj_pkg.sv
// sj_pkg: shared types and constants for the Sega pad scanner.
//   sj_state_e        - scanner FSM state (IDLE, SCAN)
//   NUM_PHASES        - SELECT half-periods per scan
//   PAD_W / BTN_W     - pad pin count / published button word width
//   BTN_*             - bit positions in the published button word
//   PH_*              - scan phases that capture pad data
package sj_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } sj_state_e;

    localparam int unsigned NUM_PHASES = 8;
    localparam int unsigned PAD_W      = 6;
    localparam int unsigned BTN_W      = 12;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DN    = 1;
    localparam int unsigned BTN_LF    = 2;
    localparam int unsigned BTN_RT    = 3;
    localparam int unsigned BTN_B     = 4;
    localparam int unsigned BTN_C     = 5;
    localparam int unsigned BTN_A     = 6;
    localparam int unsigned BTN_START = 7;
    localparam int unsigned BTN_Z     = 8;
    localparam int unsigned BTN_Y     = 9;
    localparam int unsigned BTN_X     = 10;
    localparam int unsigned BTN_MODE  = 11;

    // SELECT high: UP,DN,LF,RT,B,C
    localparam logic [2:0] PH_BASE_H = 3'd0;
    // SELECT low: A,START and the presence pins (LF/RT forced low by the pad)
    localparam logic [2:0] PH_BASE_L = 3'd1;
    // Third SELECT low: a 6-button pad pulls UP,DN,LF,RT all low
    localparam logic [2:0] PH_SIX_L  = 3'd5;
    // Fourth SELECT high: a 6-button pad reports Z,Y,X,MODE
    localparam logic [2:0] PH_EXT_H  = 3'd6;
    localparam logic [2:0] PH_LAST   = 3'(NUM_PHASES - 1);

endpackage

// File: rtl/sj_sync.sv
// sj_sync: multi-stage synchronizer for the raw pad pins.
//   clk, reset  - system clock, asynchronous active-high reset
//   d           - raw asynchronous pad pins (active-low)
//   q           - synchronized pins; reset to all-ones so an idle pad reads "not pressed"
module sj_sync
    import sj_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PAD_W-1:0] d,
    output logic [PAD_W-1:0] q
);

    if (SYNC_STAGES < 1) begin : g_bad_stages
        $error("sj_sync: SYNC_STAGES must be at least 1");
    end

    logic [PAD_W-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                stage_q[i] <= '1;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/sega_pad_scanner.sv
// sega_pad_scanner: sequences the Sega 3/6-button pad read protocol.
//   clk, reset  - system clock, asynchronous active-high reset
//   tick        - 1-clk phase strobe; all protocol timing advances on it
//   pad_in      - raw pad pins, active-low {TR,TL,RT,LF,DN,UP}
//   frame_req   - frame request pulse (only when SJ_FRAME_REQ_EN is defined)
//   pad_select  - SELECT pin to the pad
//   buttons     - active-high {MODE,X,Y,Z,START,A,C,B,RT,LF,DN,UP}
//   present     - pad detected in the last frame
//   six_btn     - 6-button pad detected in the last frame
//   valid       - 1-clk strobe: buttons/present/six_btn updated this cycle
// Build option: define SJ_FRAME_REQ_EN to gate each scan on a frame_req pulse
// instead of free-running.
module sega_pad_scanner
    import sj_pkg::*;
#(
    parameter int unsigned IDLE_TICKS  = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [PAD_W-1:0] pad_in,
`ifdef SJ_FRAME_REQ_EN
    input  logic             frame_req,
`endif
    output logic             pad_select,
    output logic [BTN_W-1:0] buttons,
    output logic             present,
    output logic             six_btn,
    output logic             valid
);

    if (IDLE_TICKS < 2 || IDLE_TICKS > 256) begin : g_bad_idle
        $error("sega_pad_scanner: IDLE_TICKS must be in 2..256");
    end

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_TICKS - 1);

    // Synchronized pins, converted to active-high
    logic [PAD_W-1:0] pad_sync;
    logic [PAD_W-1:0] s;

    sj_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pad_in),
        .q     (pad_sync)
    );

    assign s = ~pad_sync;

    sj_state_e  state_q, state_d;
    logic [7:0] idle_ctr_q, idle_ctr_d;
    logic [2:0] phase_q, phase_d;
    logic       idle_expired;
    logic       scan_go;
    logic       commit;
    logic       pad_select_d;

    assign idle_expired = (idle_ctr_q == IDLE_LAST);

`ifdef SJ_FRAME_REQ_EN
    logic req_pending_q;

    assign scan_go = tick && (state_q == IDLE) && idle_expired && req_pending_q;

    // A request arriving on the same clk as scan start is kept for the next frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_pending_q <= 1'b0;
        end else begin
            req_pending_q <= frame_req | (req_pending_q & ~scan_go);
        end
    end
`else
    assign scan_go = tick && (state_q == IDLE) && idle_expired;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idle_ctr_q <= '0;
            phase_q    <= '0;
        end else begin
            state_q    <= state_d;
            idle_ctr_q <= idle_ctr_d;
            phase_q    <= phase_d;
        end
    end

    // Next state
    always_comb begin
        state_d    = state_q;
        idle_ctr_d = idle_ctr_q;
        phase_d    = phase_q;
        case (state_q)
            IDLE: begin
                if (scan_go) begin
                    state_d    = SCAN;
                    idle_ctr_d = '0;
                    phase_d    = '0;
                end else if (tick && !idle_expired) begin
                    // Saturates at IDLE_LAST while waiting for a request
                    idle_ctr_d = idle_ctr_q + 8'd1;
                end
            end
            SCAN: begin
                if (tick) begin
                    phase_d = phase_q + 3'd1;
                    if (phase_q == PH_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: SELECT follows the next phase parity so the pin comes straight from a flop
    always_comb begin
        pad_select_d = (state_d == IDLE) || !phase_d[0];
        commit       = (state_q == SCAN) && tick && (phase_q == PH_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pad_select <= 1'b1;
        end else begin
            pad_select <= pad_select_d;
        end
    end

    // Per-phase shadow captures
    logic [PAD_W-1:0] base_h_q;
    logic             a_q;
    logic             start_q;
    logic             pres_q;
    logic             six_q;
    logic [3:0]       ext_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_h_q <= '0;
            a_q      <= 1'b0;
            start_q  <= 1'b0;
            pres_q   <= 1'b0;
            six_q    <= 1'b0;
            ext_q    <= '0;
        end else if (tick && (state_q == SCAN)) begin
            case (phase_q)
                PH_BASE_H: base_h_q <= s;
                PH_BASE_L: begin
                    a_q     <= s[4];
                    start_q <= s[5];
                    pres_q  <= s[2] & s[3];
                end
                PH_SIX_L: six_q <= &s[3:0];
                PH_EXT_H: ext_q <= s[3:0];
                default: ;
            endcase
        end
    end

    // Assemble the frame result from the shadows
    logic [BTN_W-1:0] frame_word;
    logic             frame_six;

    always_comb begin
        frame_word            = '0;
        frame_word[BTN_UP]    = base_h_q[0];
        frame_word[BTN_DN]    = base_h_q[1];
        frame_word[BTN_LF]    = base_h_q[2];
        frame_word[BTN_RT]    = base_h_q[3];
        frame_word[BTN_B]     = base_h_q[4];
        frame_word[BTN_C]     = base_h_q[5];
        frame_word[BTN_A]     = a_q;
        frame_word[BTN_START] = start_q;
        frame_word[BTN_Z]     = ext_q[0];
        frame_word[BTN_Y]     = ext_q[1];
        frame_word[BTN_X]     = ext_q[2];
        frame_word[BTN_MODE]  = ext_q[3];
        frame_six             = pres_q & six_q;
        if (!pres_q) begin
            frame_word = '0;
        end else if (!frame_six) begin
            frame_word[BTN_MODE:BTN_Z] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buttons <= '0;
            present <= 1'b0;
            six_btn <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= commit;
            if (commit) begin
                buttons <= frame_word;
                present <= pres_q;
                six_btn <= frame_six;
            end
        end
    end

endmodule

// File: tb/tb_sega_pad_scanner.sv
// Testbench for sega_pad_scanner: drives ticks and a behavioural pad, predicts each
// frame result into a queue, and a negedge monitor pops and compares on every valid.
module tb_sega_pad_scanner;
    import sj_pkg::*;

    localparam int unsigned IDLE_TICKS  = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          MAX_TICKS   = 200;

    // Pad kinds
    localparam int K_NONE = 0;
    localparam int K_3BTN = 1;
    localparam int K_6BTN = 2;
    localparam int K_RAND = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick;
    logic [PAD_W-1:0] pad_in;
    logic             pad_select;
    logic [BTN_W-1:0] buttons;
    logic             present;
    logic             six_btn;
    logic             valid;
`ifdef SJ_FRAME_REQ_EN
    logic             frame_req = 1'b0;
`endif

    sega_pad_scanner #(
        .IDLE_TICKS  (IDLE_TICKS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .pad_in     (pad_in),
`ifdef SJ_FRAME_REQ_EN
        .frame_req  (frame_req),
`endif
        .pad_select (pad_select),
        .buttons    (buttons),
        .present    (present),
        .six_btn    (six_btn),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BTN_W-1:0] buttons;
        logic             present;
        logic             six;
        int               due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t last_exp;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    endfunction

    // ---------------- reference model ----------------
    // Frame = IDLE_TICKS idle ticks (SELECT high), then 8 scan ticks sampling phases 0..7.
    int             idle_seen;
    int             ph;         // -1 while idle, else the phase the next tick samples
    bit             pend;
    bit             frame_done;
    logic [PAD_W-1:0] act_rec [NUM_PHASES];

    function automatic bit req_ok();
`ifdef SJ_FRAME_REQ_EN
        return pend;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] exp_sel();
        return (ph < 0 || (ph % 2) == 0) ? 32'd1 : 32'd0;
    endfunction

    function automatic exp_t frame_result(logic [5:0] a0, logic [5:0] a1,
                                          logic [5:0] a5, logic [5:0] a6);
        exp_t r;
        r.present = a1[2] & a1[3];
        r.six     = r.present & (&a5[3:0]);
        r.buttons = {a6[3:0], a1[5], a1[4], a0[5:0]};
        if (!r.present) r.buttons = '0;
        else if (!r.six) r.buttons[11:8] = '0;
        r.due = 0;
        return r;
    endfunction

    // Active-high pin levels a pad of the given kind presents while the scanner is in phase
    function automatic logic [5:0] pad_act(int kind, logic [11:0] b, int phase);
        logic sel_hi;
        sel_hi = (phase < 0) || ((phase % 2) == 0);
        case (kind)
            K_NONE: return 6'h00;
            K_RAND: return 6'($urandom);
            default: begin
                if (kind == K_6BTN && phase == 6)
                    return {b[BTN_C], b[BTN_B], b[BTN_MODE], b[BTN_X], b[BTN_Y], b[BTN_Z]};
                if (kind == K_6BTN && phase == 5)
                    return {b[BTN_START], b[BTN_A], 4'b1111};
                if (sel_hi)
                    return {b[BTN_C], b[BTN_B], b[BTN_RT], b[BTN_LF], b[BTN_DN], b[BTN_UP]};
                return {b[BTN_START], b[BTN_A], 2'b11, b[BTN_DN], b[BTN_UP]};
            end
        endcase
    endfunction

    task automatic model_tick(input logic [5:0] act);
        exp_t e;
        if (ph < 0) begin
            if (idle_seen + 1 >= int'(IDLE_TICKS) && req_ok()) begin
                ph        = 0;
                idle_seen = 0;
                pend      = 1'b0;
            end else if (idle_seen + 1 < int'(IDLE_TICKS)) begin
                idle_seen++;
            end
        end else begin
            act_rec[ph] = act;
            if (ph == NUM_PHASES - 1) begin
                e          = frame_result(act_rec[0], act_rec[1], act_rec[5], act_rec[6]);
                e.due      = cyc + 1;
                exp_q.push_back(e);
                last_exp   = e;
                ph         = -1;
                frame_done = 1'b1;
            end else begin
                ph++;
            end
        end
    endtask

    function automatic void model_reset();
        idle_seen        = 0;
        ph               = -1;
        pend             = 1'b0;
        last_exp.buttons = '0;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: valid=1 at cycle %0d, expected no frame due", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("valid_cycle", 32'(cyc), 32'(mon_e.due));
                chk("present", 32'(present), 32'(mon_e.present));
                chk("six_btn", 32'(six_btn), 32'(mon_e.six));
                chk("buttons", 32'(buttons), 32'(mon_e.buttons));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic request();
`ifdef SJ_FRAME_REQ_EN
        @(negedge clk);
        frame_req = 1'b1;
        pend      = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
`endif
    endtask

    task automatic issue_tick(input int kind, input logic [11:0] btn);
        logic [5:0] act;
        @(negedge clk);
        chk("pad_select", 32'(pad_select), exp_sel());
        chk("hold_buttons", 32'(buttons), 32'(last_exp.buttons));
        act    = pad_act(kind, btn, ph);
        pad_in = ~act;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        tick = 1'b1;
        model_tick(act);
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic run_frame(input int kind, input logic [11:0] btn);
        int n;
        request();
        frame_done = 1'b0;
        n          = 0;
        while (!frame_done && n < MAX_TICKS) begin
            issue_tick(kind, btn);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tick  = 1'b1;   // must be ignored while reset is held
        #1;
        chk("rst_pad_select", 32'(pad_select), 32'd1);
        chk("rst_buttons", 32'(buttons), 32'd0);
        chk("rst_present", 32'(present), 32'd0);
        chk("rst_six_btn", 32'(six_btn), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [11:0] btn;
        int          kind;
        reset  = 1'b1;
        tick   = 1'b0;
        pad_in = '1;
        model_reset();
        do_reset();

        // Directed frames
        run_frame(K_NONE, 12'h000);
        run_frame(K_3BTN, 12'h041);   // A + UP
        run_frame(K_6BTN, 12'h4A0);   // X + START + C

        // Randomized frames
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 3));
            btn  = 12'($urandom);
            if (kind == K_3BTN && btn[BTN_UP]) btn[BTN_DN] = 1'b0;
            run_frame(kind, btn);
        end

        // Reset while the scan is in phase 3: no partial frame may be committed
        request();
        for (int k = 0; k < MAX_TICKS && ph != 3; k++) issue_tick(K_6BTN, 12'hFFF);
        do_reset();
        run_frame(K_6BTN, 12'($urandom));

        // Back-to-back ticks from a fresh idle period with a constant pad
        do_reset();
        pad_in = ~6'h0F;
        request();
        repeat (SYNC_STAGES + 1) @(negedge clk);
        for (int i = 0; i < int'(IDLE_TICKS) + NUM_PHASES; i++) begin
            @(negedge clk);
            chk("b2b_pad_select", 32'(pad_select), exp_sel());
            tick = 1'b1;
            model_tick(6'h0F);
        end
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);

`ifdef SJ_FRAME_REQ_EN
        // Without a request the scanner must stay idle with SELECT high
        for (int i = 0; i < 50; i++) issue_tick(K_NONE, 12'h000);
        run_frame(K_6BTN, 12'($urandom));
`endif

        repeat (5) @(negedge clk);
        chk("outstanding_frames", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
